// File: rtl/sqmul_arb_pkg.sv
// Shared definitions for the sqmul_arb arbiter/sequencer: FSM state encoding,
// the quiet-NaN abort value and the default watchdog limit.
package sqmul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] QNAN            = 32'h7FC0_0000;
  localparam int          DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/sqmul_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last+1 (mod N), reported as valid, one-hot sel and binary idx.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [N-1:0]  sel,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // NOTE: every output gets a default before the scan so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    sel   = '0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        sel[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqmul_arb.sv
// Round-robin arbiter/sequencer sharing one float_sq_mul unit between NUM_REQ
// requesters. Define SQMUL_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module sqmul_arb
  import sqmul_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] sq_in,
  input  logic [32*NUM_REQ-1:0] mul_in,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           result,
  output logic                  err,
  output logic                  u_start,
  output logic [31:0]           u_sq,
  output logic [31:0]           u_mul,
  input  logic                  u_ready,
  input  logic [31:0]           u_result
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("sqmul_arb: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  state_t               state;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        last;
  logic                 pick_valid;
  logic [NUM_REQ-1:0]   pick_sel;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   idx_onehot;

  assign idx_onehot = NUM_REQ'(1) << idx;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .sel   (pick_sel),
    .idx   (pick_idx)
  );

`ifdef SQMUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          wd_expired;

  assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));

  // Counts WAIT cycles; err rises with done only when the watchdog fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
      err    <= (state == WAIT) && !u_ready && wd_expired;
    end
  end
`else
  assign err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      last    <= IW'(NUM_REQ - 1);
      grant   <= '0;
      done    <= '0;
      result  <= '0;
      u_start <= 1'b0;
      u_sq    <= '0;
      u_mul   <= '0;
    end else begin
      grant   <= '0;
      done    <= '0;
      u_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            u_sq  <= sq_in[32*pick_idx +: 32];
            u_mul <= mul_in[32*pick_idx +: 32];
            idx   <= pick_idx;
            grant <= pick_sel;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          u_start <= 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          // done is launched here so it is visible in the cycle after ready.
          if (u_ready) begin
            result <= u_result;
            last   <= idx;
            done   <= idx_onehot;
            state  <= RESP;
          end
`ifdef SQMUL_ARB_TIMEOUT_EN
          else if (wd_expired) begin
            result <= QNAN;
            last   <= idx;
            done   <= idx_onehot;
            state  <= RESP;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqmul_arb.sv
// Self-checking bench for sqmul_arb: randomized requests against a
// round-robin reference model and a stand-in float_sq_mul unit.
module tb_sqmul_arb;

  localparam int N = 2;
`ifdef SQMUL_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] sq_op [2];
  logic [31:0] mul_op [2];
  logic [63:0] sq_in, mul_in;
  logic [1:0]  grant, done;
  logic [31:0] result, u_sq, u_mul, u_result;
  logic        err, u_start, u_ready;

  logic        model_ready = 1'b0;
  logic [31:0] model_res = '0;
  logic        spur_ready = 1'b0;
  logic [31:0] spur_res = '0;
  int          lat = 7;
  bit          unit_mute = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int model_last = N - 1;

  assign sq_in    = {sq_op[1], sq_op[0]};
  assign mul_in   = {mul_op[1], mul_op[0]};
  assign u_ready  = model_ready | spur_ready;
  assign u_result = spur_ready ? spur_res : model_res;

  always #5 clk = ~clk;

  sqmul_arb #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .sq_in    (sq_in),
    .mul_in   (mul_in),
    .grant    (grant),
    .done     (done),
    .result   (result),
    .err      (err),
    .u_start  (u_start),
    .u_sq     (u_sq),
    .u_mul    (u_mul),
    .u_ready  (u_ready),
    .u_result (u_result)
  );

  // Stand-in for float_sq_mul: exact sq*sq*mul for the known operand pairs,
  // an operand-dependent tag otherwise so misrouted operands are visible.
  function automatic logic [31:0] unit_fn(input logic [31:0] s, input logic [31:0] m);
    if (s == 32'h4000_0000 && m == 32'h3F00_0000) return 32'h4000_0000;
    if (s == 32'h3FC0_0000 && m == 32'h4000_0000) return 32'h4090_0000;
    return {s[15:0], m[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [1:0] onehot(input int i);
    logic [1:0] v;
    v = 2'b01;
    return v << i;
  endfunction

  // Round-robin rule: first pending requester after the last one served.
  function automatic int model_pick(input logic [1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (model_last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (u_start === 1'b1 && !unit_mute) begin
        logic [31:0] s, m;
        s = u_sq;
        m = u_mul;
        repeat (lat - 1) @(negedge clk);
        if (rst_n) begin
          model_res   = unit_fn(s, m);
          model_ready = 1'b1;
          @(negedge clk);
          model_ready = 1'b0;
        end
      end
    end
  end

  task automatic do_op(input string tag, input bit drop_at_grant,
                       output int w, output logic [31:0] r);
    int exp_w;
    bit got;
    exp_w = model_pick(req);
    w = -1;
    r = 'x;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (grant !== 2'b00) got = 1'b1;
    end
    total_cnt++;
    if (!got) begin
      $display("FAIL %s_grant: no grant in 40 cycles, expected requester %0d", tag, exp_w);
      return;
    end
    if (grant !== onehot(exp_w))
      $display("FAIL %s_grant: grant=%b expected %b", tag, grant, onehot(exp_w));
    else pass_cnt++;
    w = grant[1] ? 1 : 0;
    if (drop_at_grant) req[exp_w] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (done !== 2'b00) got = 1'b1;
    end
    total_cnt++;
    if (!got) begin
      $display("FAIL %s_done: no done in 60 cycles, expected requester %0d", tag, exp_w);
      return;
    end
    if (done !== onehot(exp_w) || err !== 1'b0)
      $display("FAIL %s_done: done=%b err=%b expected done=%b err=0", tag, done, err, onehot(exp_w));
    else pass_cnt++;
    total_cnt++;
    if (result !== unit_fn(sq_op[exp_w], mul_op[exp_w]))
      $display("FAIL %s_result: result=%h expected %h", tag, result, unit_fn(sq_op[exp_w], mul_op[exp_w]));
    else pass_cnt++;
    r = result;
    model_last = exp_w;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b00;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({grant, done, err, u_start} !== 6'b0)
      $display("FAIL reset_ctrl: grant=%b done=%b err=%b u_start=%b expected all 0", grant, done, err, u_start);
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0) $display("FAIL reset_result: result=%h expected 0", result);
    else pass_cnt++;
    total_cnt++;
    if ({u_sq, u_mul} !== 64'h0) $display("FAIL reset_ops: u_sq=%h u_mul=%h expected 0", u_sq, u_mul);
    else pass_cnt++;
    rst_n = 1'b1;
    model_last = N - 1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (grant !== 2'b00) $display("FAIL idle_no_req: grant=%b expected 00", grant);
    else pass_cnt++;
  endtask

  task automatic test_single();
    bit got;
    int cyc;
    sq_op[0] = 32'h4000_0000;
    mul_op[0] = 32'h3F00_0000;
    lat = 7;
    req = 2'b01;
    @(negedge clk);
    total_cnt++;
    if (grant !== 2'b01 || u_start !== 1'b0)
      $display("FAIL single_grant: grant=%b u_start=%b expected 01/0", grant, u_start);
    else pass_cnt++;
    total_cnt++;
    if (u_sq !== 32'h4000_0000 || u_mul !== 32'h3F00_0000)
      $display("FAIL single_ops: u_sq=%h u_mul=%h expected 40000000/3f000000", u_sq, u_mul);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (u_start !== 1'b1 || grant !== 2'b00)
      $display("FAIL single_start: u_start=%b grant=%b expected 1/00", u_start, grant);
    else pass_cnt++;
    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      cyc = c;
      if (done !== 2'b00) got = 1'b1;
    end
    total_cnt++;
    if (!got || cyc != lat)
      $display("FAIL single_latency: done after %0d cycles (seen=%0d) expected %0d", cyc, got, lat);
    else pass_cnt++;
    total_cnt++;
    if (done !== 2'b01 || result !== 32'h4000_0000 || err !== 1'b0)
      $display("FAIL single_done: done=%b result=%h err=%b expected 01/40000000/0", done, result, err);
    else pass_cnt++;
    req = 2'b00;
    model_last = 0;
    @(negedge clk);
    total_cnt++;
    if (done !== 2'b00) $display("FAIL single_done_width: done=%b expected 00", done);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    int w;
    logic [31:0] r;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
    sq_op[0] = 32'h4000_0000;
    mul_op[0] = 32'h3F00_0000;
    sq_op[1] = 32'h3FC0_0000;
    mul_op[1] = 32'h4000_0000;
    lat = int'($urandom_range(1, 6));
    req = 2'b11;
    do_op("cont_first", 1'b0, w, r);
    req[0] = 1'b0;
    total_cnt++;
    if (w != 0) $display("FAIL cont_order: first winner %0d expected 0", w);
    else pass_cnt++;
    do_op("cont_second", 1'b0, w, r);
    req = 2'b00;
    total_cnt++;
    if (w != 1 || r !== 32'h4090_0000)
      $display("FAIL cont_req1: winner %0d result=%h expected 1/40900000", w, r);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    int w, prev_w;
    logic [31:0] r;
    for (int i = 0; i < 2; i++) begin
      sq_op[i] = $urandom;
      mul_op[i] = $urandom;
    end
    req = 2'b11;
    prev_w = model_last;
    for (int i = 0; i < 6; i++) begin
      lat = int'($urandom_range(1, 5));
      do_op("fair", 1'b0, w, r);
      total_cnt++;
      if (w == prev_w) $display("FAIL fair_double: requester %0d granted twice in a row", w);
      else pass_cnt++;
      prev_w = w;
    end
    req = 2'b00;
  endtask

  task automatic test_spurious();
    logic [31:0] r0;
    bit seen;
    req = 2'b00;
    repeat (3) @(negedge clk);
    r0 = result;
    spur_res = $urandom | 32'h1;
    spur_ready = 1'b1;
    @(negedge clk);
    spur_ready = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 2'b00 || grant !== 2'b00) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL spurious_done: activity after idle u_ready (done=%b grant=%b)", done, grant);
    else pass_cnt++;
    total_cnt++;
    if (result !== r0) $display("FAIL spurious_result: result=%h expected %h", result, r0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w;
    logic [31:0] r;
    bit got;
    sq_op[0] = $urandom;
    mul_op[0] = $urandom;
    lat = 10;
    req = 2'b01;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (u_start === 1'b1) got = 1'b1;
    end
    total_cnt++;
    if (!got) $display("FAIL rstmid_start: u_start not seen in 20 cycles");
    else pass_cnt++;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({grant, done, err, u_start} !== 6'b0)
      $display("FAIL rstmid_ctrl: grant=%b done=%b err=%b u_start=%b expected all 0", grant, done, err, u_start);
    else pass_cnt++;
    total_cnt++;
    if ({result, u_sq, u_mul} !== 96'h0)
      $display("FAIL rstmid_data: result=%h u_sq=%h u_mul=%h expected 0", result, u_sq, u_mul);
    else pass_cnt++;
    req = 2'b00;
    repeat (15) @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
    @(negedge clk);
    sq_op[1] = $urandom;
    mul_op[1] = $urandom;
    lat = 3;
    req = 2'b10;
    do_op("post_rst", 1'b0, w, r);
    req = 2'b00;
    total_cnt++;
    if (w != 1) $display("FAIL post_rst_winner: winner %0d expected 1", w);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int w;
    logic [31:0] r;
    req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      sq_op[i] = $urandom;
      mul_op[i] = $urandom;
    end
    req = 2'($urandom_range(1, 3));
    for (int n = 0; n < 24; n++) begin
      lat = int'($urandom_range(1, 9));
      do_op("rand", $urandom_range(0, 3) == 0, w, r);
      if (w < 0) break;
      req[w] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          sq_op[i] = $urandom;
          mul_op[i] = $urandom;
          req[i] = 1'b1;
        end
      end
      if (req == 2'b00) begin
        sq_op[w] = $urandom;
        mul_op[w] = $urandom;
        req[w] = 1'b1;
      end
    end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

`ifdef SQMUL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int exp_w;
    bit got, seen;
    unit_mute = 1'b1;
    sq_op[0] = $urandom;
    mul_op[0] = $urandom;
    req = 2'b01;
    exp_w = model_pick(req);
    got = 1'b0;
    for (int c = 0; c < TO + 20 && !got; c++) begin
      @(negedge clk);
      if (done !== 2'b00) got = 1'b1;
    end
    total_cnt++;
    if (!got) $display("FAIL timeout_done: no done within %0d cycles", TO + 20);
    else pass_cnt++;
    total_cnt++;
    if (done !== onehot(exp_w) || err !== 1'b1 || result !== 32'h7FC0_0000)
      $display("FAIL timeout_abort: done=%b err=%b result=%h expected %b/1/7fc00000",
               done, err, result, onehot(exp_w));
    else pass_cnt++;
    req = 2'b00;
    model_last = exp_w;
    unit_mute = 1'b0;
    spur_res = 32'h1234_5678;
    spur_ready = 1'b1;
    @(negedge clk);
    spur_ready = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 2'b00 || err !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen || result !== 32'h7FC0_0000)
      $display("FAIL timeout_late_ready: late u_ready changed state (result=%h)", result);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    sq_op[0] = '0;
    sq_op[1] = '0;
    mul_op[0] = '0;
    mul_op[1] = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_spurious();
    test_reset_mid();
    test_random();
`ifdef SQMUL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
